// File: rtl/de10lite_input_debounce.sv
// DE10-Lite input conditioning: synchronises raw KEY/SW pins into CLK_50,
// debounces each channel against a shared prescaled tick and reports clean
// levels plus single-cycle rise/fall pulses.
module de10lite_input_debounce #(
    parameter int unsigned      WIDTH        = 12,
    parameter int unsigned      SYNC_STAGES  = 2,
    parameter int unsigned      TICK_DIV     = 50_000,
    parameter int unsigned      STABLE_TICKS = 20,
    parameter logic [WIDTH-1:0] INVERT       = '0,
    parameter logic [WIDTH-1:0] RST_VAL      = '0
) (
    input  logic             CLK_50,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             changed,
    output logic             tick
);

    localparam int unsigned PRESC_W = $clog2(TICK_DIV);
    localparam int unsigned CNT_W   = $clog2(STABLE_TICKS + 1);

    localparam logic [PRESC_W-1:0] PRESC_RELOAD = PRESC_W'(TICK_DIV - 1);
    localparam logic [PRESC_W-1:0] PRESC_ONE    = PRESC_W'(1);
    localparam logic [CNT_W-1:0]   CNT_LAST     = CNT_W'(STABLE_TICKS - 1);
    localparam logic [CNT_W-1:0]   CNT_ONE      = CNT_W'(1);

    typedef enum logic {
        StStable,
        StCheck
    } state_e;

    // Synchroniser chain; stage 0 takes the (optionally inverted) raw pin.
    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
    logic [WIDTH-1:0]                  s_in;
    logic [WIDTH-1:0]                  sync;

    logic [PRESC_W-1:0] presc_q, presc_d;
    logic               tick_q, tick_d;

    state_e             state_q [WIDTH];
    logic [CNT_W-1:0]   cnt_q   [WIDTH];
    logic [WIDTH-1:0]   dout_q;
    logic [WIDTH-1:0]   rise_q;
    logic [WIDTH-1:0]   fall_q;
    logic               changed_q;
    logic [WIDTH-1:0]   accept;

    assign s_in = din ^ INVERT;
    assign sync = sync_q[SYNC_STAGES-1];

    // Shift the synchroniser and advance the prescaler.
    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], s_in};
        tick_d  = (presc_q == '0);
        presc_d = (presc_q == '0) ? PRESC_RELOAD : presc_q - PRESC_ONE;
    end

    // Synchroniser and prescaler state.
    always_ff @(posedge CLK_50) begin
        if (rst) begin
            sync_q  <= {SYNC_STAGES{RST_VAL}};
            presc_q <= PRESC_RELOAD;
            tick_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            presc_q <= presc_d;
            tick_q  <= tick_d;
        end
    end

    // A channel accepts its new level on the tick that completes qualification.
    always_comb begin
        accept = '0;
        for (int i = 0; i < WIDTH; i++) begin
            accept[i] = (state_q[i] == StCheck) && (sync[i] != dout_q[i]) && tick_q &&
                        (cnt_q[i] == CNT_LAST);
        end
    end

    // Per-channel debounce FSMs with registered level and edge outputs.
    always_ff @(posedge CLK_50) begin
        if (rst) begin
            dout_q    <= RST_VAL;
            rise_q    <= '0;
            fall_q    <= '0;
            changed_q <= 1'b0;
            for (int i = 0; i < WIDTH; i++) begin
                state_q[i] <= StStable;
                cnt_q[i]   <= '0;
            end
        end else begin
            dout_q    <= (dout_q & ~accept) | (sync & accept);
            rise_q    <= accept & sync;
            fall_q    <= accept & ~sync;
            changed_q <= |accept;
            for (int i = 0; i < WIDTH; i++) begin
                case (state_q[i])
                    StStable: begin
                        if (sync[i] != dout_q[i]) begin
                            state_q[i] <= StCheck;
                            cnt_q[i]   <= '0;
                        end
                    end
                    StCheck: begin
                        if (sync[i] == dout_q[i]) begin
                            // Bounced back before acceptance: drop it silently.
                            state_q[i] <= StStable;
                            cnt_q[i]   <= '0;
                        end else if (tick_q) begin
                            if (cnt_q[i] == CNT_LAST) begin
                                state_q[i] <= StStable;
                                cnt_q[i]   <= '0;
                            end else begin
                                cnt_q[i] <= cnt_q[i] + CNT_ONE;
                            end
                        end
                    end
                    default: begin
                        state_q[i] <= StStable;
                        cnt_q[i]   <= '0;
                    end
                endcase
            end
        end
    end

    assign dout    = dout_q;
    assign rise    = rise_q;
    assign fall    = fall_q;
    assign changed = changed_q;
    assign tick    = tick_q;

endmodule

// File: tb/tb_de10lite_input_debounce.sv
// Self-checking bench for de10lite_input_debounce: directed scenarios plus a
// randomized run compared against an edge-index based reference model.
module tb_de10lite_input_debounce;

    localparam int unsigned W   = 4;
    localparam int unsigned SS  = 2;
    localparam int unsigned TD  = 4;
    localparam int unsigned ST  = 3;
    localparam logic [3:0]  INV = 4'b0011;
    localparam logic [3:0]  RV  = 4'b0000;
    localparam int LAT_MIN = (ST - 1) * TD + SS + 2;
    localparam int LAT_MAX = ST * TD + SS + 1;

    logic       clk;
    logic       rst;
    logic [3:0] din;
    logic [3:0] dout;
    logic [3:0] rise;
    logic [3:0] fall;
    logic       changed;
    logic       tick;

    int total;
    int bad;

    de10lite_input_debounce #(
        .WIDTH       (W),
        .SYNC_STAGES (SS),
        .TICK_DIV    (TD),
        .STABLE_TICKS(ST),
        .INVERT      (INV),
        .RST_VAL     (RV)
    ) dut (
        .CLK_50 (clk),
        .rst    (rst),
        .din    (din),
        .dout   (dout),
        .rise   (rise),
        .fall   (fall),
        .changed(changed),
        .tick   (tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: m_c numbers the edges since reset release (first = 1).
    // The tick output is high after edge k when k is a nonzero multiple of TD;
    // the debouncer sees the level sampled SS edges earlier. A new level is
    // taken once it has differed from dout at every edge since the mismatch
    // was first seen and ST ticks have been observed after that first edge.
    int         m_c;
    logic [3:0] m_p1, m_p2, m_dout, m_rise, m_fall;
    logic       m_tick;
    int         m_start [W];
    int         m_cnt   [W];

    function automatic logic tick_at(input int k);
        return (k >= int'(TD)) && (k % int'(TD) == 0);
    endfunction

    initial begin
        m_c = 0; m_p1 = RV; m_p2 = RV; m_dout = RV; m_rise = '0; m_fall = '0; m_tick = 1'b0;
        for (int i = 0; i < W; i++) begin
            m_start[i] = -1;
            m_cnt[i]   = 0;
        end
        forever begin
            @(posedge clk);
            if (rst) begin
                m_c = 0; m_p1 = RV; m_p2 = RV; m_dout = RV;
                m_rise = '0; m_fall = '0; m_tick = 1'b0;
                for (int i = 0; i < W; i++) begin
                    m_start[i] = -1;
                    m_cnt[i]   = 0;
                end
            end else begin
                logic [3:0] seen;
                int lo, hi, n;
                m_c++;
                seen = m_p2;
                m_p2 = m_p1;
                m_p1 = din ^ INV;
                m_rise = '0;
                m_fall = '0;
                for (int i = 0; i < W; i++) begin
                    if (seen[i] == m_dout[i]) begin
                        m_start[i] = -1;
                        m_cnt[i]   = 0;
                    end else if (m_start[i] < 0) begin
                        m_start[i] = m_c;
                        m_cnt[i]   = 0;
                    end else begin
                        // Count multiples of TD in [max(start, TD), m_c-1].
                        lo = (m_start[i] > int'(TD)) ? m_start[i] : int'(TD);
                        hi = m_c - 1;
                        n  = (hi < lo) ? 0 : (hi / int'(TD) - (lo - 1) / int'(TD));
                        if (n >= int'(ST)) begin
                            m_dout[i]  = seen[i];
                            m_rise[i]  = seen[i];
                            m_fall[i]  = ~seen[i];
                            m_start[i] = -1;
                            m_cnt[i]   = 0;
                        end else begin
                            m_cnt[i] = n;
                        end
                    end
                end
                m_tick = tick_at(m_c);
            end
        end
    end

    task automatic step;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        din = 4'b0011;
        step;
        step;
        total++;
        if (dout !== 4'b0 || rise !== 4'b0 || fall !== 4'b0 || changed !== 1'b0 ||
            tick !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: dout=%b rise=%b fall=%b chg=%b tick=%b, want all 0",
                     dout, rise, fall, changed, tick);
        end
        rst = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            step;
            total++;
            if (dout !== 4'b0 || rise !== 4'b0 || fall !== 4'b0 || changed !== 1'b0) begin
                bad++;
                $display("FAIL idle_outputs cyc%0d: dout=%b rise=%b fall=%b chg=%b, want 0",
                         k, dout, rise, fall, changed);
            end
            total++;
            if (tick !== ((k % int'(TD)) == 0)) begin
                bad++;
                $display("FAIL tick_cadence cyc%0d: got %b want %b", k, tick,
                         ((k % int'(TD)) == 0));
            end
        end
    endtask

    task automatic test_rise;
        int n;
        bit got;
        din[2] = 1'b1;
        n = 0;
        got = 0;
        while (!got && n < 40) begin
            step;
            n++;
            if (dout[2]) got = 1;
            else begin
                total++;
                if (rise !== 4'b0 || fall !== 4'b0) begin
                    bad++;
                    $display("FAIL rise_early edge%0d: rise=%b fall=%b want 0", n, rise, fall);
                end
            end
        end
        total++;
        if (!got) begin
            bad++;
            $display("FAIL rise_timeout: dout=%b after %0d edges, want dout[2]=1", dout, n);
        end else begin
            total++;
            if (n < LAT_MIN || n > LAT_MAX) begin
                bad++;
                $display("FAIL rise_latency: got %0d edges want %0d..%0d", n, LAT_MIN, LAT_MAX);
            end
            total++;
            if (rise !== 4'b0100 || fall !== 4'b0000 || changed !== 1'b1) begin
                bad++;
                $display("FAIL rise_pulse: rise=%b fall=%b chg=%b want 0100 0000 1",
                         rise, fall, changed);
            end
            step;
            total++;
            if (rise !== 4'b0 || changed !== 1'b0 || dout !== 4'b0100) begin
                bad++;
                $display("FAIL rise_one_cycle: rise=%b chg=%b dout=%b want 0000 0 0100",
                         rise, changed, dout);
            end
        end
    endtask

    task automatic test_glitch;
        for (int k = 0; k < 36; k++) begin
            din[3] = (k < 6);
            step;
            total++;
            if (dout[3] !== 1'b0 || rise[3] !== 1'b0 || fall[3] !== 1'b0) begin
                bad++;
                $display("FAIL glitch_reject cyc%0d: dout3=%b rise3=%b fall3=%b want 0 0 0",
                         k, dout[3], rise[3], fall[3]);
            end
        end
    endtask

    task automatic test_bounce;
        int pulses;
        int n;
        bit got;
        pulses = 0;
        for (int b = 0; b < 3; b++) begin
            for (int h = 0; h < 4; h++) begin
                din[0] = (h >= 2);
                step;
                if (rise[0]) pulses++;
                total++;
                if (dout[0] !== 1'b0) begin
                    bad++;
                    $display("FAIL bounce_hold b%0d: dout0=%b want 0", b, dout[0]);
                end
            end
        end
        din[0] = 1'b0;
        n = 0;
        got = 0;
        while (!got && n < 40) begin
            step;
            n++;
            if (rise[0]) pulses++;
            if (dout[0]) got = 1;
        end
        total++;
        if (!got) begin
            bad++;
            $display("FAIL bounce_timeout: dout0=%b after %0d edges want 1", dout[0], n);
        end else begin
            total++;
            if (n < LAT_MIN || n > LAT_MAX) begin
                bad++;
                $display("FAIL bounce_latency: got %0d edges want %0d..%0d",
                         n, LAT_MIN, LAT_MAX);
            end
        end
        repeat (10) begin
            step;
            if (rise[0]) pulses++;
        end
        total++;
        if (pulses !== 1) begin
            bad++;
            $display("FAIL bounce_pulses: got %0d rise0 pulses want 1", pulses);
        end
        total++;
        if (dout[0] !== 1'b1) begin
            bad++;
            $display("FAIL bounce_level: dout0=%b want 1", dout[0]);
        end
    endtask

    task automatic test_back_to_back;
        int n;
        bit got;
        logic prev;
        din[2] = 1'b0;
        repeat (40) step;
        total++;
        if (dout !== 4'b0001) begin
            bad++;
            $display("FAIL simul_settle: dout=%b want 0001", dout);
        end
        din[3:2] = 2'b11;
        prev = changed;
        n = 0;
        got = 0;
        while (!got && n < 40) begin
            step;
            n++;
            if (dout[3:2] != 2'b00) got = 1;
            else prev = changed;
        end
        total++;
        if (!got) begin
            bad++;
            $display("FAIL simul_timeout: dout=%b after %0d edges want 11xx", dout, n);
        end else begin
            total++;
            if (n < LAT_MIN || n > LAT_MAX) begin
                bad++;
                $display("FAIL simul_latency: got %0d edges want %0d..%0d", n, LAT_MIN, LAT_MAX);
            end
            total++;
            if (dout[3:2] !== 2'b11 || rise !== 4'b1100 || fall !== 4'b0 || changed !== 1'b1 ||
                prev !== 1'b0) begin
                bad++;
                $display("FAIL simul_pulse: dout=%b rise=%b fall=%b chg=%b prev=%b want 11 1100 0 1 0",
                         dout, rise, fall, changed, prev);
            end
            step;
            total++;
            if (changed !== 1'b0 || rise !== 4'b0) begin
                bad++;
                $display("FAIL simul_single: chg=%b rise=%b want 0 0000", changed, rise);
            end
        end
    endtask

    task automatic test_reset_mid_check;
        int n;
        bit got;
        din[3:2] = 2'b00;
        repeat (40) step;
        total++;
        if (dout !== 4'b0001) begin
            bad++;
            $display("FAIL midrst_settle: dout=%b want 0001", dout);
        end
        din[2] = 1'b1;
        n = 0;
        while (m_cnt[2] != 2 && n < 40) begin
            step;
            n++;
            total++;
            if (rise !== 4'b0 || dout[2] !== 1'b0) begin
                bad++;
                $display("FAIL midrst_qualify edge%0d: rise=%b dout2=%b want 0 0", n, rise, dout[2]);
            end
        end
        total++;
        if (m_cnt[2] != 2) begin
            bad++;
            $display("FAIL midrst_reach: model count %0d want 2", m_cnt[2]);
        end
        rst = 1'b1;
        step;
        total++;
        if (dout !== 4'b0 || rise !== 4'b0 || fall !== 4'b0 || changed !== 1'b0 ||
            tick !== 1'b0) begin
            bad++;
            $display("FAIL midrst_state: dout=%b rise=%b fall=%b chg=%b tick=%b want all 0",
                     dout, rise, fall, changed, tick);
        end
        rst = 1'b0;
        n = 0;
        got = 0;
        while (!got && n < 40) begin
            step;
            n++;
            if (dout[2]) got = 1;
            else begin
                total++;
                if (rise[2] !== 1'b0) begin
                    bad++;
                    $display("FAIL midrst_early edge%0d: rise2=%b want 0", n, rise[2]);
                end
            end
        end
        total++;
        if (!got) begin
            bad++;
            $display("FAIL midrst_timeout: dout=%b after %0d edges want dout2=1", dout, n);
        end else begin
            total++;
            if (n < LAT_MIN || n > LAT_MAX || rise[2] !== 1'b1) begin
                bad++;
                $display("FAIL midrst_requalify: %0d edges rise2=%b want %0d..%0d and 1",
                         n, rise[2], LAT_MIN, LAT_MAX);
            end
        end
    endtask

    task automatic test_random;
        logic m_chg;
        for (int k = 0; k < 600; k++) begin
            for (int i = 0; i < W; i++) begin
                if ($urandom_range(0, 11) == 0) din[i] = ~din[i];
            end
            rst = ($urandom_range(0, 249) == 0);
            step;
            m_chg = |(m_rise | m_fall);
            total++;
            if ({dout, rise, fall, changed, tick} !== {m_dout, m_rise, m_fall, m_chg, m_tick}) begin
                bad++;
                $display("FAIL random cyc%0d: got dout=%b rise=%b fall=%b chg=%b tick=%b want %b %b %b %b %b",
                         k, dout, rise, fall, changed, tick, m_dout, m_rise, m_fall, m_chg, m_tick);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        din   = 4'b0011;
        @(negedge clk);
        test_reset;
        test_rise;
        test_glitch;
        test_bounce;
        test_back_to_back;
        test_reset_mid_check;
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
